// File: rtl/cache_pkg.sv
// ============================================================================
// Package  : cache_pkg -- shared types and width helpers for cache_sa_engine
// Revision : 1.0 (macro CACHE_NEXTLINE_PREFETCH_EN adds prefetch states)
// ============================================================================
`default_nettype none

package cache_pkg;

   typedef enum logic {REPL_FIFO = 1'b0, REPL_LRU = 1'b1} replace_e;
   typedef enum logic {WP_THROUGH = 1'b0, WP_BACK = 1'b1} wpol_e;

`ifdef CACHE_NEXTLINE_PREFETCH_EN
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOOKUP    = 3'd1,
      ST_UPDATE    = 3'd2,
      ST_RESP      = 3'd3,
      ST_PF_LOOKUP = 3'd4,
      ST_PF_UPDATE = 3'd5
   } state_e;
   localparam int unsigned N_STAT = 7;
`else
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_UPDATE = 2'd2,
      ST_RESP   = 2'd3
   } state_e;
   localparam int unsigned N_STAT = 6;
`endif

   // Statistics counter slots
   localparam int unsigned SI_READS  = 0;
   localparam int unsigned SI_WRITES = 1;
   localparam int unsigned SI_RMISS  = 2;
   localparam int unsigned SI_WMISS  = 3;
   localparam int unsigned SI_MRD    = 4;
   localparam int unsigned SI_MWR    = 5;
   localparam int unsigned SI_PF     = 6;

   localparam int unsigned TAG_MAX_W = 64;
   localparam int unsigned AGE_MAX_W = 8;

   typedef struct packed {
      logic                 valid;
      logic                 dirty;
      logic [TAG_MAX_W-1:0] tag;
      logic [AGE_MAX_W-1:0] age;
   } line_t;

   function automatic int unsigned off_w(input int unsigned block_bytes);
      return $clog2(block_bytes);
   endfunction

   function automatic int unsigned idx_w(input int unsigned num_sets);
      return $clog2(num_sets);
   endfunction

   function automatic int unsigned way_w(input int unsigned num_ways);
      return $clog2(num_ways);
   endfunction

   function automatic int unsigned tag_w(input int unsigned addr_w,
                                         input int unsigned block_bytes,
                                         input int unsigned num_sets);
      return addr_w - off_w(block_bytes) - idx_w(num_sets);
   endfunction

endpackage

`default_nettype wire

// File: rtl/cache_victim_sel.sv
// ============================================================================
// Module   : cache_victim_sel -- hit detect and victim choice for one set
// Revision : 1.0
// ============================================================================
`default_nettype none

module cache_victim_sel
   import cache_pkg::*;
#(
   parameter int unsigned NUM_WAYS = 8,
   parameter int unsigned TAG_W    = 36,
   localparam int unsigned WAY_W   = way_w(NUM_WAYS)
)(
   input  logic [NUM_WAYS-1:0]             valid,
   input  logic [NUM_WAYS-1:0][TAG_W-1:0]  tags,
   input  logic [NUM_WAYS-1:0][WAY_W-1:0]  ages,
   input  logic [TAG_W-1:0]                lookup_tag,
   output logic                            hit,
   output logic [WAY_W-1:0]                hit_way,
   output logic [WAY_W-1:0]                victim_way
);

   logic w_found_inv;
   logic w_found_old;

   always_comb begin
      hit         = 1'b0;
      hit_way     = '0;
      victim_way  = '0;
      w_found_inv = 1'b0;
      w_found_old = 1'b0;
      for (int i = 0; i < NUM_WAYS; i++) begin
         if (!hit && valid[i] && (tags[i] == lookup_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(i);
         end
      end
      // Free slots are always preferred; the oldest line is used only when the set is full
      for (int i = 0; i < NUM_WAYS; i++) begin
         if (!w_found_inv && !valid[i]) begin
            w_found_inv = 1'b1;
            victim_way  = WAY_W'(i);
         end
      end
      if (!w_found_inv) begin
         for (int i = 0; i < NUM_WAYS; i++) begin
            if (!w_found_old && (ages[i] == WAY_W'(NUM_WAYS - 1))) begin
               w_found_old = 1'b1;
               victim_way  = WAY_W'(i);
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/cache_sa_engine.sv
// ============================================================================
// Module   : cache_sa_engine -- set-associative tag/state engine, FIFO/LRU, WB/WT
// Revision : 1.0 (optional next-line prefetch: CACHE_NEXTLINE_PREFETCH_EN)
// ============================================================================
`default_nettype none

module cache_sa_engine
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W      = 48,
   parameter int unsigned BLOCK_BYTES = 64,
   parameter int unsigned NUM_SETS    = 64,
   parameter int unsigned NUM_WAYS    = 8,
   parameter int unsigned CNT_W       = 32
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_replace,
   input  logic              cfg_write_policy,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_write,
   output logic              rsp_valid,
   output logic              rsp_hit,
   output logic              rsp_evict_valid,
   output logic              rsp_evict_dirty,
   output logic [ADDR_W-1:0] rsp_evict_tag,
   input  logic              stat_clear,
   output logic [CNT_W-1:0]  stat_reads,
   output logic [CNT_W-1:0]  stat_writes,
   output logic [CNT_W-1:0]  stat_read_misses,
   output logic [CNT_W-1:0]  stat_write_misses,
   output logic [CNT_W-1:0]  stat_mem_reads,
   output logic [CNT_W-1:0]  stat_mem_writes,
   output logic [CNT_W-1:0]  stat_prefetches
);

   localparam int unsigned OFF_W = off_w(BLOCK_BYTES);
   localparam int unsigned IDX_W = idx_w(NUM_SETS);
   localparam int unsigned WAY_W = way_w(NUM_WAYS);
   localparam int unsigned TAG_W = tag_w(ADDR_W, BLOCK_BYTES, NUM_SETS);
   localparam int unsigned BLK_W = ADDR_W - OFF_W;

   state_e                         r_state, w_next;
   logic [BLK_W-1:0]               r_blk;
   logic                           r_write;
   replace_e                       r_repl;
   wpol_e                          r_wpol;
   logic                           r_hit;
   logic [WAY_W-1:0]               r_hit_way, r_vic_way;

   logic [NUM_WAYS-1:0]            r_valid [NUM_SETS];
   logic [NUM_WAYS-1:0]            r_dirty [NUM_SETS];
   logic [NUM_WAYS-1:0][TAG_W-1:0] r_tag   [NUM_SETS];
   logic [NUM_WAYS-1:0][WAY_W-1:0] r_age   [NUM_SETS];

   logic                           r_rsp_hit, r_rsp_ev_valid, r_rsp_ev_dirty;
   logic [ADDR_W-1:0]              r_rsp_ev_tag;
   logic [CNT_W-1:0]               r_stat  [N_STAT];
   logic [N_STAT-1:0]              w_inc;

   logic                           w_accept, w_pf_lookup, w_pf_update, w_pf_phase;
   logic                           w_is_lookup, w_rq_update, w_is_update;
   logic                           w_req_write, w_wb, w_fill, w_vic_valid, w_vic_dirty;
   logic [BLK_W-1:0]               w_cur_blk;
   logic [IDX_W-1:0]               w_cur_idx;
   logic [TAG_W-1:0]               w_cur_tag;
   logic [NUM_WAYS-1:0]            w_set_valid, w_set_dirty;
   logic [NUM_WAYS-1:0][TAG_W-1:0] w_set_tag;
   logic [NUM_WAYS-1:0][WAY_W-1:0] w_set_age;
   logic                           w_sel_hit;
   logic [WAY_W-1:0]               w_sel_hit_way, w_sel_vic_way;
   logic                           w_unused_addr;

   assign w_unused_addr = ^req_addr[OFF_W-1:0];

`ifdef CACHE_NEXTLINE_PREFETCH_EN
   assign w_pf_lookup = (r_state == ST_PF_LOOKUP);
   assign w_pf_update = (r_state == ST_PF_UPDATE);
`else
   assign w_pf_lookup = 1'b0;
   assign w_pf_update = 1'b0;
`endif

   assign req_ready   = (r_state == ST_IDLE) && !reset;
   assign w_accept    = req_valid && req_ready;
   assign w_pf_phase  = w_pf_lookup || w_pf_update;
   assign w_is_lookup = (r_state == ST_LOOKUP) || w_pf_lookup;
   assign w_rq_update = (r_state == ST_UPDATE);
   assign w_is_update = w_rq_update || w_pf_update;

   // Prefetch walks the next block; block-address arithmetic wraps naturally
   assign w_cur_blk   = w_pf_phase ? (r_blk + BLK_W'(1)) : r_blk;
   assign w_cur_idx   = w_cur_blk[IDX_W-1:0];
   assign w_cur_tag   = w_cur_blk[BLK_W-1:IDX_W];

   assign w_set_valid = r_valid[w_cur_idx];
   assign w_set_dirty = r_dirty[w_cur_idx];
   assign w_set_tag   = r_tag[w_cur_idx];
   assign w_set_age   = r_age[w_cur_idx];

   assign w_req_write = r_write && !w_pf_phase;
   assign w_wb        = (r_wpol == WP_BACK);
   assign w_fill      = w_is_update && !r_hit && (!w_req_write || w_wb);
   assign w_vic_valid = w_set_valid[r_vic_way];
   assign w_vic_dirty = w_set_dirty[r_vic_way];

   cache_victim_sel #(
      .NUM_WAYS   (NUM_WAYS),
      .TAG_W      (TAG_W)
   ) u_victim_sel (
      .valid      (w_set_valid),
      .tags       (w_set_tag),
      .ages       (w_set_age),
      .lookup_tag (w_cur_tag),
      .hit        (w_sel_hit),
      .hit_way    (w_sel_hit_way),
      .victim_way (w_sel_vic_way)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:      if (w_accept) w_next = ST_LOOKUP;
         ST_LOOKUP:    w_next = ST_UPDATE;
         ST_UPDATE:    w_next = ST_RESP;
`ifdef CACHE_NEXTLINE_PREFETCH_EN
         ST_RESP:      w_next = (!r_write && !r_hit) ? ST_PF_LOOKUP : ST_IDLE;
         ST_PF_LOOKUP: w_next = ST_PF_UPDATE;
         ST_PF_UPDATE: w_next = ST_IDLE;
`else
         ST_RESP:      w_next = ST_IDLE;
`endif
         default:      w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_blk     <= '0;
         r_write   <= 1'b0;
         r_repl    <= REPL_FIFO;
         r_wpol    <= WP_THROUGH;
         r_hit     <= 1'b0;
         r_hit_way <= '0;
         r_vic_way <= '0;
      end else begin
         if (w_accept) begin
            r_blk   <= req_addr[ADDR_W-1:OFF_W];
            r_write <= req_write;
            r_repl  <= replace_e'(cfg_replace);
            r_wpol  <= wpol_e'(cfg_write_policy);
         end
         if (w_is_lookup) begin
            r_hit     <= w_sel_hit;
            r_hit_way <= w_sel_hit_way;
            r_vic_way <= w_sel_vic_way;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
            r_tag[s]   <= '0;
            r_age[s]   <= '0;
         end
      end else if (w_is_update) begin
         if (r_hit) begin
            if (!w_pf_phase && (r_repl == REPL_LRU)) begin
               for (int j = 0; j < NUM_WAYS; j++) begin
                  if (WAY_W'(j) == r_hit_way)
                     r_age[w_cur_idx][j] <= '0;
                  else if (w_set_valid[j] && (w_set_age[j] < w_set_age[r_hit_way]))
                     r_age[w_cur_idx][j] <= w_set_age[j] + WAY_W'(1);
               end
            end
            if (w_req_write && w_wb)
               r_dirty[w_cur_idx][r_hit_way] <= 1'b1;
         end else if (w_fill) begin
            for (int j = 0; j < NUM_WAYS; j++) begin
               if (WAY_W'(j) == r_vic_way) begin
                  r_valid[w_cur_idx][j] <= 1'b1;
                  r_dirty[w_cur_idx][j] <= w_req_write && w_wb;
                  r_tag[w_cur_idx][j]   <= w_cur_tag;
                  r_age[w_cur_idx][j]   <= '0;
               end else if (w_set_valid[j]) begin
                  r_age[w_cur_idx][j]   <= w_set_age[j] + WAY_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rsp_hit      <= 1'b0;
         r_rsp_ev_valid <= 1'b0;
         r_rsp_ev_dirty <= 1'b0;
         r_rsp_ev_tag   <= '0;
      end else if (w_rq_update) begin
         r_rsp_hit      <= r_hit;
         r_rsp_ev_valid <= w_fill && w_vic_valid;
         r_rsp_ev_dirty <= w_fill && w_vic_valid && w_vic_dirty;
         r_rsp_ev_tag   <= (w_fill && w_vic_valid) ? ADDR_W'(w_set_tag[r_vic_way]) : '0;
      end
   end

   always_comb begin
      w_inc            = '0;
      w_inc[SI_READS]  = w_accept && !req_write;
      w_inc[SI_WRITES] = w_accept && req_write;
      w_inc[SI_RMISS]  = w_rq_update && !r_hit && !r_write;
      w_inc[SI_WMISS]  = w_rq_update && !r_hit && r_write;
      w_inc[SI_MRD]    = w_fill;
      // Dirty writeback on fill, or every write-through store reaching memory
      w_inc[SI_MWR]    = (w_fill && w_vic_valid && w_vic_dirty) ||
                         (w_rq_update && r_write && !w_wb);
`ifdef CACHE_NEXTLINE_PREFETCH_EN
      w_inc[SI_PF]     = w_pf_update && !r_hit;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_STAT; i++) r_stat[i] <= '0;
      end else if (stat_clear) begin
         for (int i = 0; i < N_STAT; i++) r_stat[i] <= '0;
      end else begin
         for (int i = 0; i < N_STAT; i++)
            if (w_inc[i] && (r_stat[i] != {CNT_W{1'b1}}))
               r_stat[i] <= r_stat[i] + CNT_W'(1);
      end
   end

   assign rsp_valid         = (r_state == ST_RESP);
   assign rsp_hit           = r_rsp_hit;
   assign rsp_evict_valid   = r_rsp_ev_valid;
   assign rsp_evict_dirty   = r_rsp_ev_dirty;
   assign rsp_evict_tag     = r_rsp_ev_tag;
   assign stat_reads        = r_stat[SI_READS];
   assign stat_writes       = r_stat[SI_WRITES];
   assign stat_read_misses  = r_stat[SI_RMISS];
   assign stat_write_misses = r_stat[SI_WMISS];
   assign stat_mem_reads    = r_stat[SI_MRD];
   assign stat_mem_writes   = r_stat[SI_MWR];
`ifdef CACHE_NEXTLINE_PREFETCH_EN
   assign stat_prefetches   = r_stat[SI_PF];
`else
   assign stat_prefetches   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_sa_engine.sv
// ============================================================================
// Module   : tb_cache_sa_engine -- directed bench for cache_sa_engine (CNT_W=4)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cache_sa_engine;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cfg_replace = 1'b1;
   logic        cfg_write_policy = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [47:0] req_addr = '0;
   logic        req_write = 1'b0;
   logic        rsp_valid, rsp_hit, rsp_evict_valid, rsp_evict_dirty;
   logic [47:0] rsp_evict_tag;
   logic        stat_clear = 1'b0;
   logic [3:0]  stat_reads, stat_writes, stat_read_misses, stat_write_misses;
   logic [3:0]  stat_mem_reads, stat_mem_writes, stat_prefetches;

   int checks = 0;
   int errors = 0;

   logic        got_hit, got_evv, got_evd;
   logic [47:0] got_evt;

   always #5 clk = ~clk;

   cache_sa_engine #(
      .ADDR_W(48), .BLOCK_BYTES(64), .NUM_SETS(64), .NUM_WAYS(8), .CNT_W(4)
   ) dut (
      .clk(clk), .reset(reset),
      .cfg_replace(cfg_replace), .cfg_write_policy(cfg_write_policy),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_write(req_write),
      .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
      .rsp_evict_valid(rsp_evict_valid), .rsp_evict_dirty(rsp_evict_dirty),
      .rsp_evict_tag(rsp_evict_tag), .stat_clear(stat_clear),
      .stat_reads(stat_reads), .stat_writes(stat_writes),
      .stat_read_misses(stat_read_misses), .stat_write_misses(stat_write_misses),
      .stat_mem_reads(stat_mem_reads), .stat_mem_writes(stat_mem_writes),
      .stat_prefetches(stat_prefetches)
   );

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1; req_valid = 1'b0; stat_clear = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic send(input logic [47:0] a, input logic w);
      int n;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      req_addr = a; req_write = w; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (!rsp_valid) begin
         errors++;
         $display("FAIL rsp_timeout addr=%0h got rsp_valid=0 exp 1", a);
      end
      got_hit = rsp_hit; got_evv = rsp_evict_valid;
      got_evd = rsp_evict_dirty; got_evt = rsp_evict_tag;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low got %b exp 0", req_ready); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", req_ready); end
      checks++; if ({rsp_valid, rsp_hit, rsp_evict_valid, rsp_evict_dirty} !== 4'b0) begin errors++; $display("FAIL rst_rsp got %b exp 0000", {rsp_valid, rsp_hit, rsp_evict_valid, rsp_evict_dirty}); end
      checks++; if (rsp_evict_tag !== 48'h0) begin errors++; $display("FAIL rst_evtag got %0h exp 0", rsp_evict_tag); end
      checks++; if ({stat_reads, stat_writes, stat_mem_reads, stat_mem_writes, stat_prefetches} !== 20'h0) begin errors++; $display("FAIL rst_stats got %0h exp 0", {stat_reads, stat_writes, stat_mem_reads, stat_mem_writes, stat_prefetches}); end
      @(negedge clk);
   endtask

   task automatic test_read_hit();
      apply_reset();
      cfg_replace = 1'b1; cfg_write_policy = 1'b1;
      send(48'h1000, 1'b0);
      checks++; if (got_hit !== 1'b0) begin errors++; $display("FAIL rd_first_hit got %b exp 0", got_hit); end
      checks++; if (got_evv !== 1'b0) begin errors++; $display("FAIL rd_first_evv got %b exp 0", got_evv); end
      send(48'h1000, 1'b0);
      checks++; if (got_hit !== 1'b1) begin errors++; $display("FAIL rd_second_hit got %b exp 1", got_hit); end
      checks++; if (stat_reads !== 4'd2) begin errors++; $display("FAIL rd_stat_reads got %0d exp 2", stat_reads); end
      checks++; if (stat_read_misses !== 4'd1) begin errors++; $display("FAIL rd_stat_rmiss got %0d exp 1", stat_read_misses); end
      checks++; if (stat_mem_reads !== 4'd1) begin errors++; $display("FAIL rd_stat_mrd got %0d exp 1", stat_mem_reads); end
   endtask

   task automatic test_replace(input logic lru, input logic [47:0] exp_tag);
      apply_reset();
      cfg_replace = lru; cfg_write_policy = 1'b1;
      for (int k = 0; k < 8; k++) send(48'(k) << 12, 1'b0);
      send(48'h0, 1'b0);
      checks++; if (got_hit !== 1'b1) begin errors++; $display("FAIL repl%0d_rehit got %b exp 1", lru, got_hit); end
      send(48'h8000, 1'b0);
      checks++; if (got_hit !== 1'b0 || got_evv !== 1'b1 || got_evd !== 1'b0) begin errors++; $display("FAIL repl%0d_evict hit/evv/evd got %b%b%b exp 010", lru, got_hit, got_evv, got_evd); end
      checks++; if (got_evt !== exp_tag) begin errors++; $display("FAIL repl%0d_evtag got %0h exp %0h", lru, got_evt, exp_tag); end
      checks++; if (stat_read_misses !== 4'd9) begin errors++; $display("FAIL repl%0d_rmiss got %0d exp 9", lru, stat_read_misses); end
   endtask

   task automatic test_write_back();
      apply_reset();
      cfg_replace = 1'b1; cfg_write_policy = 1'b1;
      send(48'h0, 1'b1);
      checks++; if (got_hit !== 1'b0) begin errors++; $display("FAIL wb_first got %b exp 0", got_hit); end
      for (int k = 1; k <= 8; k++) send(48'(k) << 12, 1'b0);
      checks++; if ({got_evv, got_evd} !== 2'b11) begin errors++; $display("FAIL wb_evict evv/evd got %b%b exp 11", got_evv, got_evd); end
      checks++; if (got_evt !== 48'h0) begin errors++; $display("FAIL wb_evtag got %0h exp 0", got_evt); end
      checks++; if (stat_mem_writes !== 4'd1) begin errors++; $display("FAIL wb_mwr got %0d exp 1", stat_mem_writes); end
      checks++; if (stat_write_misses !== 4'd1 || stat_writes !== 4'd1) begin errors++; $display("FAIL wb_wstats got %0d/%0d exp 1/1", stat_write_misses, stat_writes); end
      checks++; if (stat_mem_reads !== 4'd9) begin errors++; $display("FAIL wb_mrd got %0d exp 9", stat_mem_reads); end
   endtask

   task automatic test_write_through();
      apply_reset();
      cfg_replace = 1'b1; cfg_write_policy = 1'b0;
      send(48'h3000, 1'b1);
      checks++; if (got_hit !== 1'b0 || got_evv !== 1'b0) begin errors++; $display("FAIL wt_wmiss hit/evv got %b%b exp 00", got_hit, got_evv); end
      checks++; if (stat_mem_writes !== 4'd1 || stat_mem_reads !== 4'd0) begin errors++; $display("FAIL wt_mem got mwr=%0d mrd=%0d exp 1/0", stat_mem_writes, stat_mem_reads); end
      send(48'h3000, 1'b0);
      checks++; if (got_hit !== 1'b0) begin errors++; $display("FAIL wt_noalloc got %b exp 0", got_hit); end
      // Policy flips to write-back after accept; the in-flight write must stay write-through
      fork
         send(48'h3000, 1'b1);
         begin @(posedge clk); #2; cfg_write_policy = 1'b1; end
      join
      checks++; if (got_hit !== 1'b1 || stat_mem_writes !== 4'd2) begin errors++; $display("FAIL wt_whit got hit=%b mwr=%0d exp 1/2", got_hit, stat_mem_writes); end
   endtask

   task automatic test_handshake();
      logic bad;
      apply_reset();
      cfg_replace = 1'b1; cfg_write_policy = 1'b1;
      req_addr = 48'h1000; req_write = 1'b0; req_valid = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (req_ready !== (i % 4 == 0) || rsp_valid !== (i % 4 == 3)) begin
            bad = 1'b1;
            $display("FAIL hs_cycle%0d got ready=%b rsp=%b exp %b/%b", i, req_ready, rsp_valid, (i % 4 == 0), (i % 4 == 3));
         end
         if (i == 7) req_valid = 1'b0;
         @(negedge clk);
      end
      checks++; if (bad) errors++;
      checks++; if (stat_reads !== 4'd2) begin errors++; $display("FAIL hs_reads got %0d exp 2", stat_reads); end
   endtask

   task automatic test_reset_mid();
      logic bad;
      apply_reset();
      send(48'h1000, 1'b0);
      req_addr = 48'h1000; req_write = 1'b0; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; reset = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1; if (rsp_valid !== 1'b0) bad = 1'b1;
         if (i == 1) reset = 1'b0;
         @(negedge clk);
      end
      checks++; if (bad) begin errors++; $display("FAIL mid_rst_rsp got rsp_valid=1 exp 0"); end
      checks++; if (stat_reads !== 4'd0 || stat_mem_reads !== 4'd0) begin errors++; $display("FAIL mid_rst_stats got %0d/%0d exp 0/0", stat_reads, stat_mem_reads); end
      send(48'h1000, 1'b0);
      checks++; if (got_hit !== 1'b0) begin errors++; $display("FAIL mid_rst_miss got %b exp 0", got_hit); end
   endtask

   task automatic test_saturation();
      int n;
      apply_reset();
      for (int i = 0; i < 20; i++) send(48'h40, 1'b0);
      checks++; if (stat_reads !== 4'd15) begin errors++; $display("FAIL sat_reads got %0d exp 15", stat_reads); end
      checks++; if (stat_read_misses !== 4'd1) begin errors++; $display("FAIL sat_rmiss got %0d exp 1", stat_read_misses); end
      req_addr = 48'h40; req_write = 1'b0; req_valid = 1'b1; stat_clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; stat_clear = 1'b0;
      checks++; if (stat_reads !== 4'd0) begin errors++; $display("FAIL clr_prio got %0d exp 0", stat_reads); end
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      checks++; if (rsp_hit !== 1'b1 || stat_mem_reads !== 4'd0) begin errors++; $display("FAIL clr_after got hit=%b mrd=%0d exp 1/0", rsp_hit, stat_mem_reads); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_read_hit();
      test_replace(1'b1, 48'h1);
      test_replace(1'b0, 48'h0);
      test_write_back();
      test_write_through();
      test_handshake();
      test_reset_mid();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
